// File: rtl/pipe_pkg.sv
// Shared types and constants for the RV32I pipeline sequencing controller.
package pipe_pkg;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_IMWAIT = 2'd1,
    S_DMWAIT = 2'd2,
    S_REDIR  = 2'd3
  } state_t;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

endpackage

// File: rtl/pipe_ctrl_dep_cmp.sv
// Register dependency comparator: one ID source against one stage destination.
// x0 never creates a dependency.
module dep_cmp (
  input  logic [4:0] src_addr,
  input  logic       src_use,
  input  logic [4:0] rd_addr,
  input  logic       rd_wr,
  output logic       match
);

  assign match = src_use && rd_wr && (rd_addr != 5'd0) && (src_addr == rd_addr);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stage enables, bubbles/flushes, forwarding selects.
// Build option: define PIPE_CTRL_FORWARD_EN to enable operand forwarding.
module pipe_ctrl
  import pipe_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [4:0]  i_id_rs1_addr,
  input  logic [4:0]  i_id_rs2_addr,
  input  logic        i_id_rs1_use,
  input  logic        i_id_rs2_use,
  input  logic [4:0]  i_ex_rd_addr,
  input  logic [4:0]  i_mem_rd_addr,
  input  logic [4:0]  i_wb_rd_addr,
  input  logic        i_ex_rd_wr,
  input  logic        i_mem_rd_wr,
  input  logic        i_wb_rd_wr,
  input  logic        i_ex_DM_OE,
  input  logic        i_ex_redirect,
  input  logic        i_im_busy,
  input  logic        i_dm_busy,
  output logic        o_pc_en,
  output logic        o_if_id_en,
  output logic        o_id_ex_en,
  output logic        o_ex_mem_en,
  output logic        o_mem_wb_en,
  output logic        o_if_id_flush,
  output logic        o_id_ex_flush,
  output logic [1:0]  o_fwd_rs1_sel,
  output logic [1:0]  o_fwd_rs2_sel,
  output logic [31:0] o_stall_cnt
);

  state_t state, state_nxt;

  logic rs1_ex, rs1_mem, rs1_wb;
  logic rs2_ex, rs2_mem, rs2_wb;
  logic hazard;
  logic unused_sigs;

  dep_cmp u_rs1_ex  (.src_addr(i_id_rs1_addr), .src_use(i_id_rs1_use),
                     .rd_addr(i_ex_rd_addr),  .rd_wr(i_ex_rd_wr),  .match(rs1_ex));
  dep_cmp u_rs1_mem (.src_addr(i_id_rs1_addr), .src_use(i_id_rs1_use),
                     .rd_addr(i_mem_rd_addr), .rd_wr(i_mem_rd_wr), .match(rs1_mem));
  dep_cmp u_rs1_wb  (.src_addr(i_id_rs1_addr), .src_use(i_id_rs1_use),
                     .rd_addr(i_wb_rd_addr),  .rd_wr(i_wb_rd_wr),  .match(rs1_wb));
  dep_cmp u_rs2_ex  (.src_addr(i_id_rs2_addr), .src_use(i_id_rs2_use),
                     .rd_addr(i_ex_rd_addr),  .rd_wr(i_ex_rd_wr),  .match(rs2_ex));
  dep_cmp u_rs2_mem (.src_addr(i_id_rs2_addr), .src_use(i_id_rs2_use),
                     .rd_addr(i_mem_rd_addr), .rd_wr(i_mem_rd_wr), .match(rs2_mem));
  dep_cmp u_rs2_wb  (.src_addr(i_id_rs2_addr), .src_use(i_id_rs2_use),
                     .rd_addr(i_wb_rd_addr),  .rd_wr(i_wb_rd_wr),  .match(rs2_wb));

`ifdef PIPE_CTRL_FORWARD_EN
  // Only a load in EX cannot be forwarded in time; everything else bypasses.
  assign hazard      = i_ex_DM_OE && (rs1_ex || rs2_ex);
  // WB matches are covered by the write-first register file.
  assign unused_sigs = rs1_wb ^ rs2_wb;

  always_comb begin
    o_fwd_rs1_sel = FWD_RF;
    o_fwd_rs2_sel = FWD_RF;
    if (i_rst_n) begin
      if (rs1_ex)       o_fwd_rs1_sel = FWD_EXMEM;
      else if (rs1_mem) o_fwd_rs1_sel = FWD_MEMWB;
      if (rs2_ex)       o_fwd_rs2_sel = FWD_EXMEM;
      else if (rs2_mem) o_fwd_rs2_sel = FWD_MEMWB;
    end
  end
`else
  // Without bypassing, wait until the producer has reached WB.
  assign hazard        = rs1_ex || rs1_mem || rs2_ex || rs2_mem;
  assign unused_sigs   = rs1_wb ^ rs2_wb ^ i_ex_DM_OE;
  assign o_fwd_rs1_sel = FWD_RF;
  assign o_fwd_rs2_sel = FWD_RF;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= S_RUN;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    o_pc_en       = 1'b0;
    o_if_id_en    = 1'b0;
    o_id_ex_en    = 1'b0;
    o_ex_mem_en   = 1'b0;
    o_mem_wb_en   = 1'b0;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    if (!i_rst_n) begin
      state_nxt     = S_RUN;
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
    end else if (i_dm_busy) begin
      state_nxt = S_DMWAIT;
    end else if (state == S_REDIR) begin
      // Target already loaded; squash the wrong-path word until it returns.
      o_if_id_en    = 1'b1;
      o_id_ex_en    = 1'b1;
      o_ex_mem_en   = 1'b1;
      o_mem_wb_en   = 1'b1;
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
      state_nxt     = i_im_busy ? S_REDIR : S_RUN;
    end else if (i_ex_redirect) begin
      o_pc_en       = 1'b1;
      o_if_id_en    = 1'b1;
      o_id_ex_en    = 1'b1;
      o_ex_mem_en   = 1'b1;
      o_mem_wb_en   = 1'b1;
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
      state_nxt     = i_im_busy ? S_REDIR : S_RUN;
    end else if (i_im_busy || hazard) begin
      o_id_ex_en    = 1'b1;
      o_ex_mem_en   = 1'b1;
      o_mem_wb_en   = 1'b1;
      o_id_ex_flush = 1'b1;
      state_nxt     = i_im_busy ? S_IMWAIT : S_RUN;
    end else begin
      o_pc_en     = 1'b1;
      o_if_id_en  = 1'b1;
      o_id_ex_en  = 1'b1;
      o_ex_mem_en = 1'b1;
      o_mem_wb_en = 1'b1;
      state_nxt   = S_RUN;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)      o_stall_cnt <= 32'd0;
    else if (!o_pc_en) o_stall_cnt <= o_stall_cnt + 32'd1;
  end

endmodule
